multicycle_controller: RTL

Multi-cycle sequencer for the MIPS datapath: steps each instruction through fetch, decode, execute, memory and write-back states and drives every datapath strobe and mux select. It sits beside the single-cycle opcode decoder and replaces it when the datapath shares one memory port and one ALU across cycles. It stalls on a memory ready handshake and halts on an illegal opcode.

---
 rtl/mcu_pkg.sv | 82 ++++++++
 rtl/multicycle_ctrl_decode.sv | 80 ++++++++
 rtl/multicycle_controller.sv | 82 ++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
// MULTICYCLE_JUMP_EN enables decoding of J; without it J is illegal.
package mcu_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;

  typedef enum logic [STATE_W-1:0] {
    RST_S    = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    WB_MEM   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    WB_R     = 4'd8,
    EXEC_I   = 4'd9,
    WB_I     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    HALT     = 4'd13
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010
  } aluOp_t;

  typedef enum logic [1:0] {
    SRCB_RT     = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMMSH2 = 2'b11
  } aluSrcB_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcSource_t;

  typedef struct packed {
    logic      pcWrite;
    logic      pcWriteCond;
    logic      iord;
    logic      memRead;
    logic      memWrite;
    logic      irWrite;
    logic      regDst;
    logic      memToReg;
    logic      regWrite;
    logic      aluSrcA;
    aluSrcB_t  aluSrcB;
    aluOp_t    aluOp;
    pcSource_t pcSource;
    logic      halted;
  } ctrl_t;

  // Successor of DECODE for a given opcode.
  function automatic state_t decodeTarget(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_R:         return EXEC_R;
      OP_LW, OP_SW: return MEM_ADDR;
      OP_ADDI:      return EXEC_I;
      OP_BEQ:       return BRANCH;
`ifdef MULTICYCLE_JUMP_EN
      OP_J:         return JUMP;
`endif
      default:      return HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state -> control-vector decode (Moore outputs).
// JUMP strobes exist only with MULTICYCLE_JUMP_EN.
module multicycle_ctrl_decode
  import mcu_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl.pcWrite     = 1'b0;
    ctrl.pcWriteCond = 1'b0;
    ctrl.iord        = 1'b0;
    ctrl.memRead     = 1'b0;
    ctrl.memWrite    = 1'b0;
    ctrl.irWrite     = 1'b0;
    ctrl.regDst      = 1'b0;
    ctrl.memToReg    = 1'b0;
    ctrl.regWrite    = 1'b0;
    ctrl.aluSrcA     = 1'b0;
    ctrl.aluSrcB     = SRCB_RT;
    ctrl.aluOp       = ALU_ADD;
    ctrl.pcSource    = PCSRC_ALU;
    ctrl.halted      = 1'b0;
    case (state)
      // pcWrite/irWrite are further qualified by mem_ready at the top level
      FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.irWrite = 1'b1;
        ctrl.pcWrite = 1'b1;
      end
      DECODE:   ctrl.aluSrcB = SRCB_IMMSH2;
      MEM_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
      end
      MEM_RD: begin
        ctrl.iord    = 1'b1;
        ctrl.memRead = 1'b1;
      end
      WB_MEM: begin
        ctrl.memToReg = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      MEM_WR: begin
        ctrl.iord     = 1'b1;
        ctrl.memWrite = 1'b1;
      end
      EXEC_R: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = ALU_FUNCT;
      end
      WB_R: begin
        ctrl.regDst   = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      EXEC_I: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
      end
      WB_I: ctrl.regWrite = 1'b1;
      BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluOp       = ALU_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
      end
`ifdef MULTICYCLE_JUMP_EN
      JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
      end
`endif
      HALT:    ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: state register, next-state logic, FETCH handshake.
// MULTICYCLE_JUMP_EN adds the J instruction and JUMP state.
module multicycle_controller
  import mcu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic [3:0] state
);

  state_t stateReg;
  ctrl_t  ctrl;
  logic   inFetch;
  logic   fetchDone;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= RST_S;
    end else begin
      case (stateReg)
        RST_S:    stateReg <= FETCH;
        FETCH:    stateReg <= mem_ready ? DECODE : FETCH;
        DECODE:   stateReg <= decodeTarget(OpCode);
        MEM_ADDR: stateReg <= (OpCode == OP_LW) ? MEM_RD :
                              (OpCode == OP_SW) ? MEM_WR : HALT;
        MEM_RD:   stateReg <= mem_ready ? WB_MEM : MEM_RD;
        WB_MEM:   stateReg <= FETCH;
        MEM_WR:   stateReg <= mem_ready ? FETCH : MEM_WR;
        EXEC_R:   stateReg <= WB_R;
        WB_R:     stateReg <= FETCH;
        EXEC_I:   stateReg <= WB_I;
        WB_I:     stateReg <= FETCH;
        BRANCH:   stateReg <= FETCH;
        JUMP:     stateReg <= FETCH;
        HALT:     stateReg <= HALT;
        default:  stateReg <= RST_S;
      endcase
    end
  end

  multicycle_ctrl_decode uDecode (
    .state (stateReg),
    .ctrl  (ctrl)
  );

  // IR and PC load only on the cycle the fetch read actually completes.
  assign inFetch   = (stateReg == FETCH);
  assign fetchDone = mem_ready && !rst;

  assign pc_write      = inFetch ? (ctrl.pcWrite && fetchDone) : ctrl.pcWrite;
  assign ir_write      = ctrl.irWrite && fetchDone;
  assign pc_write_cond = ctrl.pcWriteCond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.memRead;
  assign mem_write     = ctrl.memWrite;
  assign reg_dst       = ctrl.regDst;
  assign mem_to_reg    = ctrl.memToReg;
  assign reg_write     = ctrl.regWrite;
  assign alu_src_a     = ctrl.aluSrcA;
  assign alu_src_b     = ctrl.aluSrcB;
  assign alu_op        = ctrl.aluOp;
  assign pc_source     = ctrl.pcSource;
  assign halted        = ctrl.halted;
  assign state         = stateReg;

endmodule
